// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   - Bus field widths (address, data, byte strobes).
//   - Default read data returned to a master whose transfer was aborted.
//   - Arbiter FSM state encoding.
package bus_pkg;

   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned StrbWidth = 4;

   localparam logic [DataWidth-1:0] ErrRdataDefault = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StAbort
   } bus_state_e;

endpackage

// File: rtl/bus_timeout.sv
// Loadable up-counter with terminal-count flag, used to bound slave response time.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset (count -> 0)
//   clear_i  synchronous clear (count -> 0), has priority over en_i
//   en_i     increment enable
//   tc_o     high while the count equals TermCount
module bus_timeout #(
   parameter int unsigned Width     = 8,
   parameter int unsigned TermCount = 254
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic tc_o
);

   logic [Width-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == Width'(TermCount));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a single shared slave bus, with a
// per-transfer timeout that aborts the transfer and returns an error.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   m0_*/m1_* valid,addr,wdata,wstrb master requests (wstrb == 0 means read)
//   m0_*/m1_* ready,rdata,err        completion pulse, read data, abort flag
//   s_valid,s_addr,s_wdata,s_wstrb   request driven onto the slave bus
//   s_ready,s_rdata                  slave acknowledge and read data
//   err_count                        saturating count of timeout aborts
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned          TIMEOUT   = 255,
   parameter logic [DataWidth-1:0] ERR_RDATA = ErrRdataDefault
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 m0_valid,
   input  logic [AddrWidth-1:0] m0_addr,
   input  logic [DataWidth-1:0] m0_wdata,
   input  logic [StrbWidth-1:0] m0_wstrb,
   output logic                 m0_ready,
   output logic [DataWidth-1:0] m0_rdata,
   output logic                 m0_err,
   input  logic                 m1_valid,
   input  logic [AddrWidth-1:0] m1_addr,
   input  logic [DataWidth-1:0] m1_wdata,
   input  logic [StrbWidth-1:0] m1_wstrb,
   output logic                 m1_ready,
   output logic [DataWidth-1:0] m1_rdata,
   output logic                 m1_err,
   output logic                 s_valid,
   output logic [AddrWidth-1:0] s_addr,
   output logic [DataWidth-1:0] s_wdata,
   output logic [StrbWidth-1:0] s_wstrb,
   input  logic                 s_ready,
   input  logic [DataWidth-1:0] s_rdata,
   output logic [7:0]           err_count
);

   localparam int unsigned CntWidth = $clog2(TIMEOUT);

   bus_state_e state_d, state_q;
   logic       owner_d, owner_q;
   logic       last_d, last_q;
   logic [7:0] err_count_d, err_count_q;

   logic busy, abort, owner_valid, done_ok, timeout_tc;

   assign busy        = (state_q == StBusy);
   assign abort       = (state_q == StAbort);
   assign owner_valid = owner_q ? m1_valid : m0_valid;
   // A slave ack only completes a transfer whose owner is still requesting.
   assign done_ok     = busy && owner_valid && s_ready;

   // Counter is held at zero outside BUSY, so every grant starts from 0.
   bus_timeout #(
      .Width     (CntWidth),
      .TermCount (TIMEOUT - 1)
   ) u_timeout (
      .clk_i   (clk),
      .rst_i   (reset),
      .clear_i (!busy),
      .en_i    (busy),
      .tc_o    (timeout_tc)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      err_count_d = err_count_q;
      unique case (state_q)
         StIdle: begin
            if (m0_valid || m1_valid) begin
               state_d = StBusy;
               // On contention, grant the master that was not served last.
               owner_d = (m0_valid && m1_valid) ? !last_q : m1_valid;
            end
         end
         StBusy: begin
            if (!owner_valid) begin
               state_d = StIdle;
            end else if (s_ready) begin
               state_d = StIdle;
               last_d  = owner_q;
            end else if (timeout_tc) begin
               state_d = StAbort;
            end
         end
         StAbort: begin
            state_d = StIdle;
            last_d  = owner_q;
            if (err_count_q != 8'hFF) begin
               err_count_d = err_count_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         err_count_q <= err_count_d;
      end
   end

   always_comb begin
      s_valid  = busy;
      s_addr   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      m0_ready = 1'b0;
      m0_err   = 1'b0;
      m0_rdata = '0;
      m1_ready = 1'b0;
      m1_err   = 1'b0;
      m1_rdata = '0;
      if (busy) begin
         s_addr  = owner_q ? m1_addr  : m0_addr;
         s_wdata = owner_q ? m1_wdata : m0_wdata;
         s_wstrb = owner_q ? m1_wstrb : m0_wstrb;
      end
      if (done_ok || abort) begin
         if (owner_q) begin
            m1_ready = 1'b1;
            m1_err   = abort;
            m1_rdata = abort ? ERR_RDATA : s_rdata;
         end else begin
            m0_ready = 1'b1;
            m0_err   = abort;
            m0_rdata = abort ? ERR_RDATA : s_rdata;
         end
      end
   end

   assign err_count = err_count_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (TIMEOUT = 8): a per-cycle vector table for
// arbitration and normal transfers, then hand sequences for timeout, the
// timeout boundary, err_count saturation and asynchronous reset mid-transfer.
module tb_bus_arbiter;

   localparam logic [31:0] A0 = 32'h0000_0010;
   localparam logic [31:0] W0 = 32'h1111_1111;
   localparam logic [3:0]  S0 = 4'h0;
   localparam logic [31:0] A1 = 32'h0000_0020;
   localparam logic [31:0] W1 = 32'hD1D1_D1D1;
   localparam logic [3:0]  S1 = 4'hF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_valid = 1'b0, m1_valid = 1'b0;
   logic [31:0] m0_addr = A0, m1_addr = A1;
   logic [31:0] m0_wdata = W0, m1_wdata = W1;
   logic [3:0]  m0_wstrb = S0, m1_wstrb = S1;
   logic        m0_ready, m1_ready, m0_err, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_ready = 1'b0;
   logic [31:0] s_rdata = 32'h0;
   logic [7:0]  err_count;

   int checks = 0;
   int failures = 0;

   bus_arbiter #(
      .TIMEOUT   (8),
      .ERR_RDATA (32'hFFFF_FFFF)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .m0_valid  (m0_valid),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_wstrb  (m0_wstrb),
      .m0_ready  (m0_ready),
      .m0_rdata  (m0_rdata),
      .m0_err    (m0_err),
      .m1_valid  (m1_valid),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_wstrb  (m1_wstrb),
      .m1_ready  (m1_ready),
      .m1_rdata  (m1_rdata),
      .m1_err    (m1_err),
      .s_valid   (s_valid),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_ready   (s_ready),
      .s_rdata   (s_rdata),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  vin;     // {m0_valid, m1_valid, s_ready}
      logic [31:0] srd;
      logic [4:0]  ef;      // {s_valid, m0_ready, m1_ready, m0_err, m1_err}
      logic [31:0] erd0;
      logic [31:0] erd1;
      logic [1:0]  eown;    // bus content expected: 0 none, 1 master 0, 2 master 1
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs[NVEC];

   function automatic vec_t mk(input logic [2:0] vin, input logic [31:0] srd,
                               input logic [4:0] ef, input logic [31:0] erd0,
                               input logic [31:0] erd1, input logic [1:0] eown);
      vec_t v;
      v.vin = vin; v.srd = srd; v.ef = ef; v.erd0 = erd0; v.erd1 = erd1; v.eown = eown;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " s_valid"},  32'(s_valid),  32'h0);
      check({tag, " m0_ready"}, 32'(m0_ready), 32'h0);
      check({tag, " m1_ready"}, 32'(m1_ready), 32'h0);
      check({tag, " m0_err"},   32'(m0_err),   32'h0);
      check({tag, " m1_err"},   32'(m1_err),   32'h0);
      check({tag, " m0_rdata"}, m0_rdata,      32'h0);
      check({tag, " m1_rdata"}, m1_rdata,      32'h0);
      check({tag, " s_addr"},   s_addr,        32'h0);
   endtask

   initial begin
      int n;
      logic [31:0] ea, ew;
      logic [3:0]  es;

      // Vector table; each row is one clock cycle starting right after reset.
      vecs[0]  = mk(3'b110, 32'h0,         5'b00000, 32'h0,         32'h0,         2'd0);
      vecs[1]  = mk(3'b111, 32'hAAAA_0001, 5'b11000, 32'hAAAA_0001, 32'h0,         2'd1);
      vecs[2]  = mk(3'b110, 32'h0,         5'b00000, 32'h0,         32'h0,         2'd0);
      vecs[3]  = mk(3'b111, 32'hCAFE_0002, 5'b10100, 32'h0,         32'hCAFE_0002, 2'd2);
      vecs[4]  = mk(3'b110, 32'h0,         5'b00000, 32'h0,         32'h0,         2'd0);
      vecs[5]  = mk(3'b111, 32'hAAAA_0003, 5'b11000, 32'hAAAA_0003, 32'h0,         2'd1);
      vecs[6]  = mk(3'b110, 32'h0,         5'b00000, 32'h0,         32'h0,         2'd0);
      vecs[7]  = mk(3'b111, 32'hCAFE_0004, 5'b10100, 32'h0,         32'hCAFE_0004, 2'd2);
      vecs[8]  = mk(3'b100, 32'h0,         5'b00000, 32'h0,         32'h0,         2'd0);
      vecs[9]  = mk(3'b100, 32'h0,         5'b10000, 32'h0,         32'h0,         2'd1);
      vecs[10] = mk(3'b100, 32'h0,         5'b10000, 32'h0,         32'h0,         2'd1);
      vecs[11] = mk(3'b100, 32'h0,         5'b10000, 32'h0,         32'h0,         2'd1);
      vecs[12] = mk(3'b101, 32'h1234_5678, 5'b11000, 32'h1234_5678, 32'h0,         2'd1);
      vecs[13] = mk(3'b001, 32'h5555_5555, 5'b00000, 32'h0,         32'h0,         2'd0);
      vecs[14] = mk(3'b010, 32'h0,         5'b00000, 32'h0,         32'h0,         2'd0);
      vecs[15] = mk(3'b010, 32'h0,         5'b10000, 32'h0,         32'h0,         2'd2);
      vecs[16] = mk(3'b000, 32'h0,         5'b10000, 32'h0,         32'h0,         2'd2);
      vecs[17] = mk(3'b110, 32'h0,         5'b00000, 32'h0,         32'h0,         2'd0);
      vecs[18] = mk(3'b111, 32'h9999_9999, 5'b10100, 32'h0,         32'h9999_9999, 2'd2);
      vecs[19] = mk(3'b000, 32'h0,         5'b00000, 32'h0,         32'h0,         2'd0);

      // Reset state, observed before any clock edge.
      #1 reset = 1'b1;
      #2;
      check_idle_outputs("reset");
      check("reset err_count", 32'(err_count), 32'h0);
      step();
      step();
      reset = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         {m0_valid, m1_valid, s_ready} = vecs[i].vin;
         s_rdata = vecs[i].srd;
         unique case (vecs[i].eown)
            2'd1:    begin ea = A0; ew = W0; es = S0; end
            2'd2:    begin ea = A1; ew = W1; es = S1; end
            default: begin ea = '0; ew = '0; es = '0; end
         endcase
         @(negedge clk);
         check($sformatf("row%0d s_valid", i),   32'(s_valid),  32'(vecs[i].ef[4]));
         check($sformatf("row%0d m0_ready", i),  32'(m0_ready), 32'(vecs[i].ef[3]));
         check($sformatf("row%0d m1_ready", i),  32'(m1_ready), 32'(vecs[i].ef[2]));
         check($sformatf("row%0d m0_err", i),    32'(m0_err),   32'(vecs[i].ef[1]));
         check($sformatf("row%0d m1_err", i),    32'(m1_err),   32'(vecs[i].ef[0]));
         check($sformatf("row%0d m0_rdata", i),  m0_rdata,      vecs[i].erd0);
         check($sformatf("row%0d m1_rdata", i),  m1_rdata,      vecs[i].erd1);
         check($sformatf("row%0d s_addr", i),    s_addr,        ea);
         check($sformatf("row%0d s_wdata", i),   s_wdata,       ew);
         check($sformatf("row%0d s_wstrb", i),   32'(s_wstrb),  32'(es));
         check($sformatf("row%0d err_count", i), 32'(err_count), 32'h0);
         step();
      end
      s_ready = 1'b0;
      s_rdata = 32'h0;

      // Timeout: m1 write, slave never answers.
      m1_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (s_valid) n++;
         if (m1_ready) break;
         step();
      end
      check("timeout m1_ready", 32'(m1_ready), 32'h1);
      check("timeout s_valid cycles", 32'(n), 32'd8);
      check("timeout m1_err", 32'(m1_err), 32'h1);
      check("timeout m1_rdata", m1_rdata, 32'hFFFF_FFFF);
      check("timeout abort s_valid", 32'(s_valid), 32'h0);
      check("timeout m0_ready", 32'(m0_ready), 32'h0);
      step();
      m1_valid = 1'b0;
      @(negedge clk);
      check("timeout err_count", 32'(err_count), 32'd1);
      check("timeout after m1_ready", 32'(m1_ready), 32'h0);
      step();

      // Boundary: s_ready on the 8th BUSY cycle completes normally.
      m0_valid = 1'b1;
      step();
      repeat (6) step();
      @(negedge clk);
      check("boundary busy7 m0_ready", 32'(m0_ready), 32'h0);
      step();
      s_ready = 1'b1;
      s_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      check("boundary s_valid", 32'(s_valid), 32'h1);
      check("boundary m0_ready", 32'(m0_ready), 32'h1);
      check("boundary m0_err", 32'(m0_err), 32'h0);
      check("boundary m0_rdata", m0_rdata, 32'h0BAD_F00D);
      step();
      s_ready = 1'b0;
      m0_valid = 1'b0;
      @(negedge clk);
      check("boundary err_count", 32'(err_count), 32'd1);
      check("boundary next s_valid", 32'(s_valid), 32'h0);
      step();

      // Saturation: 300 back-to-back aborts on m0.
      m0_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (m0_err) n++;
         if (n == 300) break;
         step();
      end
      check("saturate abort count", 32'(n), 32'd300);
      step();
      m0_valid = 1'b0;
      @(negedge clk);
      check("saturate err_count", 32'(err_count), 32'd255);
      step();

      // Asynchronous reset in the 2nd BUSY cycle of an m1 write.
      m1_valid = 1'b1;
      step();
      step();
      check("rst busy2 s_valid", 32'(s_valid), 32'h1);
      check("rst busy2 s_addr", s_addr, A1);
      #1 reset = 1'b1;
      s_ready = 1'b1;
      #1;
      check_idle_outputs("rst async");
      check("rst async err_count", 32'(err_count), 32'h0);
      step();
      reset = 1'b0;
      s_ready = 1'b0;
      m0_valid = 1'b1;
      m1_valid = 1'b1;
      @(negedge clk);
      check_idle_outputs("rst release idle");
      step();
      s_ready = 1'b1;
      s_rdata = 32'h0C0F_FEE0;
      @(negedge clk);
      check("rst first grant s_addr", s_addr, A0);
      check("rst first grant m0_ready", 32'(m0_ready), 32'h1);
      check("rst first grant m1_ready", 32'(m1_ready), 32'h0);
      check("rst first grant m0_rdata", m0_rdata, 32'h0C0F_FEE0);
      step();
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      s_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning slave cycles allowed per transfer before abort (legal range 2..1023).
REQ-002 Parameter ERR_RDATA, default 32'hFFFF_FFFF, meaning read data returned on an aborted transfer.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m0_valid / m1_valid  input  1  master 0/1 request; held high until that master's ready.
REQ-006 m0_addr / m1_addr  input  32  master byte address.
REQ-007 m0_wdata / m1_wdata  input  32  master write data.
REQ-008 m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 means read.
REQ-009 m0_ready / m1_ready  output  1  transfer-complete pulse to master.
REQ-010 m0_rdata / m1_rdata  output  32  read data to master.
REQ-011 m0_err / m1_err  output  1  timeout abort, asserted together with ready.
REQ-012 s_valid  output  1  request to shared slave bus.
REQ-013 s_addr / s_wdata / s_wstrb  output  32/32/4  owner's address, data, strobes.
REQ-014 s_ready  input  1  slave acknowledge.
REQ-015 s_rdata  input  32  slave read data.
REQ-016 err_count  output  8  saturating count of timeout aborts.

Function
REQ-017 FSM states: IDLE, BUSY, ABORT; owner register (0/1); last-served register (0/1).
REQ-018 IDLE: any valid -> BUSY next edge. Owner is the sole requester, or on contention the master not equal to last-served (round-robin).
REQ-019 s_valid = 1 exactly in BUSY; grant latency is one cycle from first valid seen in IDLE.
REQ-020 s_addr, s_wdata and s_wstrb combinationally follow the owner's inputs in BUSY; they are 0 otherwise.
REQ-021 In BUSY with s_ready = 1: owner's ready = 1 and rdata = s_rdata in the same cycle; next state IDLE; last-served <= owner.
REQ-022 Non-owner ready and err stay 0; a non-owner's rdata = 0.
REQ-023 Timeout counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
REQ-024 When the counter reaches TIMEOUT-1 without s_ready: next state ABORT.
REQ-025 ABORT lasts one cycle: s_valid = 0, owner's ready = 1, err = 1, rdata = ERR_RDATA, err_count += 1 (saturating at 255); then IDLE; last-served <= owner.
REQ-026 s_ready arriving in the same cycle the counter reaches TIMEOUT-1 counts as success, with no abort.
REQ-027 Owner dropping valid while in BUSY: next state IDLE, no ready to any master, last-served unchanged, no error.
REQ-028 s_ready while in IDLE or ABORT is ignored.
REQ-029 A master re-requesting immediately after its ready still loses to a waiting other master (no starvation).
REQ-030 Worst-case wait for a requester is one full transfer of the other master plus 1 cycle.

Reset
REQ-031 On reset assertion (asynchronous): state IDLE, owner 0, last-served 1 (master 0 wins first contention), counter 0, err_count 0.
REQ-032 During reset all m*_ready, m*_err, m*_rdata and s_valid are 0 immediately.
REQ-033 Reset mid-transfer abandons it silently, with no ready pulse.

Structure
REQ-034 Shared package bus_pkg holds the FSM state enum, the ERR_RDATA default, and the address/data/strobe width constants.
REQ-035 One sub-module bus_timeout (loadable counter with terminal-count output, width from TIMEOUT) instantiated once.

Verification
REQ-036 Single master: m0 read, addr 0x0000_0010, slave readies after 3 cycles with 0x1234_5678 -> m0_ready one cycle, m0_rdata 0x1234_5678, m0_err 0, s_valid 4 cycles.
REQ-037 Contention after reset: m0 and m1 request together -> m0 served first, then m1; with both held continuously, grants alternate m0,m1,m0,m1.
REQ-038 Timeout: TIMEOUT=8, slave never readies -> s_valid 8 cycles, then m1_ready=1, m1_err=1, m1_rdata=0xFFFF_FFFF, err_count=1; 300 aborts -> err_count holds 255.
REQ-039 Boundary: TIMEOUT=8, s_ready on 8th BUSY cycle -> normal completion, err 0, err_count unchanged.
REQ-040 Reset asserted in 2nd BUSY cycle of an m1 write -> s_valid low with no clock edge; after release m0 wins the first contention.
